// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, bus widths and the issue
// sequencer's state encoding.
package alu_pkg;

  localparam int ALU_DATA_W = 16;
  localparam int ALU_OP_W   = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD    = 3'b000,
    ALU_SUB    = 3'b001,
    ALU_MPY    = 3'b010,
    ALU_AND    = 3'b011,
    ALU_OR     = 3'b100,
    ALU_NOT    = 3'b101,
    ALU_SHIFTR = 3'b110,
    ALU_SHIFTL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WB_LOW  = 2'd2,
    WB_HIGH = 2'd3
  } state_t;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer in front of the ALU: owns ACC, issues one op at a time and
// steps the BR (C9) / MR (C10) write-back strobes.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = ALU_OP_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  // Request handshake: a request transfers on a rising edge where
  // i_req_valid && o_req_ready; payload must be stable while valid is high.
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [OP_W-1:0]   i_req_op,
  input  logic [DATA_W-1:0] i_req_operand,
  input  logic              i_req_wb_high,
  input  logic              i_acc_load_valid,
  input  logic [DATA_W-1:0] i_acc_load_data,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_acc_alu_p,
  output logic [DATA_W-1:0] o_acc_alu_q,
  output logic [OP_W-1:0]   ctrl_alu_op,
  output logic              ctrl_alu_en,
  output logic              C9,
  output logic              C10,
  input  logic [DATA_W-1:0] i_br,
  input  logic [DATA_W-1:0] i_mr,
  output logic [DATA_W-1:0] o_acc,
  output logic [DATA_W-1:0] o_mr_hold,
  output logic              o_busy,
  output logic              o_done,
  output state_t            o_dbg_state
);

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] q_lat;
  logic [OP_W-1:0]   op_lat;
  logic              wb_high_lat;
  logic [DATA_W-1:0] mr_hold;
  logic              done;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      q_lat       <= '0;
      op_lat      <= '0;
      wb_high_lat <= 1'b0;
      mr_hold     <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A direct load takes priority; a coincident request stays pending.
          if (i_acc_load_valid) begin
            acc <= i_acc_load_data;
          end else if (i_req_valid) begin
            op_lat      <= i_req_op;
            q_lat       <= i_req_operand;
            wb_high_lat <= i_req_wb_high;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          state <= i_flush ? IDLE : WB_LOW;
        end
        WB_LOW: begin
          if (i_flush) begin
            state <= IDLE;
          end else begin
            acc <= i_br;
            if (wb_high_lat) begin
              state <= WB_HIGH;
            end else begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        WB_HIGH: begin
          state <= IDLE;
          if (!i_flush) begin
            mr_hold <= i_mr;
            done    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus strobes are plain state decodes, gated by flush so an abort never
  // drives BR/MR in the cycle it arrives.
  assign ctrl_alu_en = (state == ISSUE);
  assign C9          = (state == WB_LOW)  && !i_flush;
  assign C10         = (state == WB_HIGH) && !i_flush;

  assign o_req_ready = (state == IDLE) && !i_acc_load_valid;
  assign o_busy      = (state != IDLE);
  assign o_done      = done;
  assign o_acc       = acc;
  assign o_acc_alu_p = acc;
  assign o_acc_alu_q = q_lat;
  assign ctrl_alu_op = op_lat;
  assign o_mr_hold   = mr_hold;
  assign o_dbg_state = state;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: the ALU bus results (i_br/i_mr) are
// driven by hand in the write-back cycles.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int DW = 16;
  localparam int OW = 3;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_req_valid;
  logic          o_req_ready;
  logic [OW-1:0] i_req_op;
  logic [DW-1:0] i_req_operand;
  logic          i_req_wb_high;
  logic          i_acc_load_valid;
  logic [DW-1:0] i_acc_load_data;
  logic          i_flush;
  logic [DW-1:0] o_acc_alu_p;
  logic [DW-1:0] o_acc_alu_q;
  logic [OW-1:0] ctrl_alu_op;
  logic          ctrl_alu_en;
  logic          C9;
  logic          C10;
  logic [DW-1:0] i_br;
  logic [DW-1:0] i_mr;
  logic [DW-1:0] o_acc;
  logic [DW-1:0] o_mr_hold;
  logic          o_busy;
  logic          o_done;
  state_t        o_dbg_state;

  int errors = 0;
  int checks = 0;

  alu_issue_ctrl dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_req_valid     (i_req_valid),
    .o_req_ready     (o_req_ready),
    .i_req_op        (i_req_op),
    .i_req_operand   (i_req_operand),
    .i_req_wb_high   (i_req_wb_high),
    .i_acc_load_valid(i_acc_load_valid),
    .i_acc_load_data (i_acc_load_data),
    .i_flush         (i_flush),
    .o_acc_alu_p     (o_acc_alu_p),
    .o_acc_alu_q     (o_acc_alu_q),
    .ctrl_alu_op     (ctrl_alu_op),
    .ctrl_alu_en     (ctrl_alu_en),
    .C9              (C9),
    .C10             (C10),
    .i_br            (i_br),
    .i_mr            (i_mr),
    .o_acc           (o_acc),
    .o_mr_hold       (o_mr_hold),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_dbg_state     (o_dbg_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_acc(input logic [DW-1:0] v);
    i_acc_load_valid = 1'b1;
    i_acc_load_data  = v;
    step();
    i_acc_load_valid = 1'b0;
  endtask

  task automatic request(input logic [OW-1:0] op, input logic [DW-1:0] opnd, input logic wbh);
    i_req_valid   = 1'b1;
    i_req_op      = op;
    i_req_operand = opnd;
    i_req_wb_high = wbh;
  endtask

  initial begin
    i_rst_n = 1'b0; i_req_valid = 1'b0; i_req_op = '0; i_req_operand = '0;
    i_req_wb_high = 1'b0; i_acc_load_valid = 1'b0; i_acc_load_data = '0;
    i_flush = 1'b0; i_br = '0; i_mr = '0;
    step(); step();
    i_rst_n = 1'b1;
    #1;
    chk("rst_ready", 16'(o_req_ready), 16'd1);
    chk("rst_acc", o_acc, 16'h0000);
    chk("rst_p", o_acc_alu_p, 16'h0000);
    chk("rst_q", o_acc_alu_q, 16'h0000);
    chk("rst_busy", 16'(o_busy), 16'd0);
    chk("rst_done", 16'(o_done), 16'd0);
    chk("rst_strobes", 16'({ctrl_alu_en, C9, C10}), 16'd0);
    chk("rst_mr_hold", o_mr_hold, 16'h0000);

    // 1: ADD 5 + 3
    i_acc_load_valid = 1'b1; i_acc_load_data = 16'h0005; #1;
    chk("t1_ready_during_load", 16'(o_req_ready), 16'd0);
    step(); i_acc_load_valid = 1'b0;
    chk("t1_acc_loaded", o_acc, 16'h0005);
    request(3'b000, 16'h0003, 1'b0); #1;
    chk("t1_ready", 16'(o_req_ready), 16'd1);
    step(); i_req_valid = 1'b0;
    chk("t1_en", 16'(ctrl_alu_en), 16'd1);
    chk("t1_p", o_acc_alu_p, 16'h0005);
    chk("t1_q", o_acc_alu_q, 16'h0003);
    chk("t1_op", 16'(ctrl_alu_op), 16'd0);
    chk("t1_c9_in_issue", 16'(C9), 16'd0);
    chk("t1_busy", 16'(o_busy), 16'd1);
    step(); i_br = 16'h0008; #1;
    chk("t1_c9", 16'(C9), 16'd1);
    chk("t1_en_off", 16'(ctrl_alu_en), 16'd0);
    step();
    chk("t1_acc", o_acc, 16'h0008);
    chk("t1_done", 16'(o_done), 16'd1);
    chk("t1_done_ready", 16'(o_req_ready), 16'd1);
    chk("t1_idle_strobes", 16'({ctrl_alu_en, C9, C10}), 16'd0);
    step();
    chk("t1_done_pulse", 16'(o_done), 16'd0);

    // 2: MPY 0x0100 * 0x0100 with MR write-back
    load_acc(16'h0100);
    request(3'b010, 16'h0100, 1'b1);
    step(); i_req_valid = 1'b0;
    chk("t2_en", 16'(ctrl_alu_en), 16'd1);
    chk("t2_op", 16'(ctrl_alu_op), 16'd2);
    step(); i_br = 16'h0000; i_mr = 16'h0001; #1;
    chk("t2_c9", 16'(C9), 16'd1);
    step();
    chk("t2_c10", 16'(C10), 16'd1);
    chk("t2_c9_off", 16'(C9), 16'd0);
    chk("t2_acc", o_acc, 16'h0000);
    chk("t2_no_early_done", 16'(o_done), 16'd0);
    step();
    chk("t2_mr_hold", o_mr_hold, 16'h0001);
    chk("t2_done", 16'(o_done), 16'd1);
    chk("t2_c10_off", 16'(C10), 16'd0);

    // 3: back-to-back SUBs with valid held high
    load_acc(16'h0010);
    request(3'b001, 16'h0001, 1'b0);
    step();
    chk("t3_ready_t1", 16'(o_req_ready), 16'd0);
    chk("t3_en1", 16'(ctrl_alu_en), 16'd1);
    step(); i_br = 16'h000F; #1;
    chk("t3_ready_t2", 16'(o_req_ready), 16'd0);
    step();
    chk("t3_done1", 16'(o_done), 16'd1);
    chk("t3_ready_t3", 16'(o_req_ready), 16'd1);
    chk("t3_acc1", o_acc, 16'h000F);
    step(); i_req_valid = 1'b0;
    chk("t3_en2", 16'(ctrl_alu_en), 16'd1);
    chk("t3_p2", o_acc_alu_p, 16'h000F);
    step(); i_br = 16'h000E; #1;
    chk("t3_c9_2", 16'(C9), 16'd1);
    step();
    chk("t3_acc2", o_acc, 16'h000E);
    chk("t3_done2", 16'(o_done), 16'd1);

    // 4: load wins over a simultaneous request
    i_acc_load_valid = 1'b1; i_acc_load_data = 16'h1234;
    request(3'b000, 16'h0001, 1'b0); #1;
    chk("t4_ready", 16'(o_req_ready), 16'd0);
    step(); i_acc_load_valid = 1'b0; i_req_valid = 1'b0; #1;
    chk("t4_acc", o_acc, 16'h1234);
    chk("t4_no_en", 16'(ctrl_alu_en), 16'd0);
    chk("t4_busy", 16'(o_busy), 16'd0);

    // 5: flush during ISSUE
    load_acc(16'h0F0F);
    request(3'b011, 16'h00FF, 1'b0);
    step(); i_req_valid = 1'b0; i_flush = 1'b1; i_br = 16'h000F; #1;
    chk("t5_en", 16'(ctrl_alu_en), 16'd1);
    chk("t5_c9_issue", 16'(C9), 16'd0);
    step(); i_flush = 1'b0; #1;
    chk("t5_c9", 16'(C9), 16'd0);
    chk("t5_acc", o_acc, 16'h0F0F);
    chk("t5_done", 16'(o_done), 16'd0);
    chk("t5_ready", 16'(o_req_ready), 16'd1);
    chk("t5_busy", 16'(o_busy), 16'd0);

    // 5b: flush during WB_LOW suppresses C9 and the ACC write
    request(3'b100, 16'h0001, 1'b0);
    step(); i_req_valid = 1'b0;
    step(); i_flush = 1'b1; i_br = 16'hBEEF; #1;
    chk("t5b_c9", 16'(C9), 16'd0);
    step(); i_flush = 1'b0;
    chk("t5b_acc", o_acc, 16'h0F0F);
    chk("t5b_done", 16'(o_done), 16'd0);
    chk("t5b_busy", 16'(o_busy), 16'd0);

    // 6: reset during WB_HIGH
    load_acc(16'h0001);
    request(3'b010, 16'h0002, 1'b1);
    step(); i_req_valid = 1'b0;
    step(); i_br = 16'h0002; i_mr = 16'h0005;
    step();
    chk("t6_c10_pre", 16'(C10), 16'd1);
    chk("t6_acc_pre", o_acc, 16'h0002);
    i_rst_n = 1'b0;
    step(); i_rst_n = 1'b1; #1;
    chk("t6_c10", 16'(C10), 16'd0);
    chk("t6_acc", o_acc, 16'h0000);
    chk("t6_mr_hold", o_mr_hold, 16'h0000);
    chk("t6_busy", 16'(o_busy), 16'd0);
    chk("t6_done", 16'(o_done), 16'd0);
    chk("t6_ready", 16'(o_req_ready), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
